// File: rtl/price_stats_if.sv
// rtl/price_stats_if.sv - sample-in / batch-statistics-out handshake bundle for price_stats
interface price_stats_if;
    logic [31:0] price_in;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [31:0] mean;
    logic [31:0] min;
    logic [31:0] max;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output price_in, in_valid, clear, out_ready,
        input  in_ready, mean, min, max, out_valid
    );

    modport slave (
        input  price_in, in_valid, clear, out_ready,
        output in_ready, mean, min, max, out_valid
    );
endinterface

// File: rtl/price_stats.sv
// rtl/price_stats.sv - batch mean/min/max over N = 2^LOG2_N unsigned prices
module price_stats #(
    parameter int LOG2_N = 3
) (
    input  logic         clk,
    input  logic         rst,
    price_stats_if.slave bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = 32 + LOG2_N;
    localparam int CW = LOG2_N + 1;

    typedef enum logic {ACC, OUT} state_t;

    state_t          state;
    logic [SW-1:0]   sum;
    logic [CW-1:0]   cnt;
    logic [31:0]     run_min;
    logic [31:0]     run_max;

    logic [SW-1:0]   sum_next;
    logic [31:0]     min_next;
    logic [31:0]     max_next;
    logic            first;
    logic            last;
    logic            accept;

    // The first sample of a batch seeds min/max regardless of stale running values.
    always_comb begin
        first    = (cnt == '0);
        last     = (cnt == CW'(N - 1));
        accept   = (state == ACC) && bus.in_valid && !bus.clear;
        sum_next = sum + {{LOG2_N{1'b0}}, bus.price_in};
        min_next = (first || (bus.price_in < run_min)) ? bus.price_in : run_min;
        max_next = (first || (bus.price_in > run_max)) ? bus.price_in : run_max;
    end

    assign bus.in_ready = (state == ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ACC;
            sum           <= '0;
            cnt           <= '0;
            run_min       <= '0;
            run_max       <= '0;
            bus.mean      <= '0;
            bus.min       <= '0;
            bus.max       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.clear) begin
                        sum <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        sum     <= sum_next;
                        cnt     <= cnt + 1'b1;
                        run_min <= min_next;
                        run_max <= max_next;
                        if (last) begin
                            bus.mean      <= sum_next[SW-1:LOG2_N];
                            bus.min       <= min_next;
                            bus.max       <= max_next;
                            bus.out_valid <= 1'b1;
                            state         <= OUT;
                        end
                    end
                end
                OUT: begin
                    // Results stay frozen until the consumer takes them; clear is ignored here.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        sum           <= '0;
                        cnt           <= '0;
                        state         <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: doc/price_stats.md
PRICE_STATS -- requirements
Module: price_stats

Interface
REQ-001 SHALL have parameter LOG2_N, default 3, giving log2 of the batch size N = 2^LOG2_N; legal range 1..8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port price_in  input  32  unsigned price word from the upstream linear-regression stage.
REQ-005 SHALL have port in_valid  input  1  price_in is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port clear  input  1  synchronous discard of the partial batch.
REQ-008 SHALL have port mean  output  32  floor(sum of batch / N).
REQ-009 SHALL have port min  output  32  smallest price in the batch.
REQ-010 SHALL have port max  output  32  largest price in the batch.
REQ-011 SHALL have port out_valid  output  1  mean/min/max hold a completed batch.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-013 SHALL implement a two-state FSM: ACC (collecting) and OUT (result held).
REQ-014 SHALL drive in_ready = 1 in ACC and 0 in OUT, combinationally from state only.
REQ-015 SHALL accept a sample on any rising edge in ACC where in_valid = 1 and clear = 0.
REQ-016 SHALL keep a running sum of width 32+LOG2_N, so overflow is impossible for any input.
REQ-017 SHALL keep a running min and max, compared unsigned, initialised by the first sample of each batch.
REQ-018 SHALL keep a sample counter of width LOG2_N+1, incremented per accepted sample.
REQ-019 SHALL, on accepting the N-th sample, move to OUT on that same edge.
REQ-020 SHALL, on that same edge, register mean = (sum including that sample) >> LOG2_N, min and max, with the N-th sample included.
REQ-021 SHALL assert out_valid the cycle after the N-th accept, i.e. one cycle of latency from the last accept.
REQ-022 SHALL hold mean, min, max and out_valid stable in OUT until an edge where out_ready = 1.
REQ-023 SHALL, on an edge in OUT with out_ready = 1, deassert out_valid, zero sum and counter, and return to ACC.
REQ-024 SHALL not accept a sample on the OUT->ACC edge (in_ready was 0), giving at least one idle cycle between batches.
REQ-025 SHALL, on clear = 1 in ACC, zero sum and counter and discard any sample presented that cycle (clear has priority over accept).
REQ-026 SHALL ignore clear in OUT.
REQ-027 SHALL leave mean/min/max at their last completed-batch values while in ACC; only out_valid qualifies them.
REQ-028 SHALL treat in_valid gaps as stalls: the counter and accumulators hold.

Reset
REQ-029 SHALL, while rst = 1, force state ACC, counter 0, sum 0, mean 0, min 0, max 0, out_valid 0, independent of clk.
REQ-030 SHALL discard any partial batch or held result on reset, including reset asserted mid-batch or in OUT.
REQ-031 SHALL present in_ready = 1 on the first cycle after rst deasserts.

Verification (LOG2_N = 3, N = 8)
REQ-032 Bench SHALL drive 10,20,...,80 back-to-back with out_ready = 1 -> out_valid for exactly 1 cycle, mean 45, min 10, max 80.
REQ-033 Bench SHALL drive 8 samples of 0xFFFFFFFF -> mean 0xFFFFFFFF, min and max 0xFFFFFFFF (no overflow).
REQ-034 Bench SHALL complete a batch and hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0, in_valid samples dropped; out_ready = 1 then returns to ACC.
REQ-035 Bench SHALL accept 3 samples, then assert clear with in_valid = 1 and price 999, then drive 8 samples of 4 -> mean 4, min 4, max 4 (999 absent).
REQ-036 Bench SHALL assert rst asynchronously after 5 samples, then drive 8 samples 1..8 -> mean 4, min 1, max 8.
REQ-037 Bench SHALL drive samples 7,3,9,1,5,2,8,6 with random in_valid gaps -> mean 5, min 1, max 9.
